mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter that sits directly downstream of the CPU's data-memory write port, alongside the data memory. It snoops CPU stores and captures the low byte of any store to the TX data address into a small FIFO. It then serialises each byte onto a single 8N1 line for host debug output. A read-side status word lets software poll FIFO state before storing.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104: `clk` cycles per UART bit (12 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH`, default 8: TX FIFO entries. Must be a power of two, ≥ 2.
- `TX_ADDR`, default 8'hF0: word address of the TX data register (write-only).
- `STATUS_ADDR`, default 8'hF1: word address of the status register.

Ports:
- `clk`  in  1  system clock. The only clock in the block.
- `rst`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `clk_enable`  in  1  CPU advance strobe from the clock divider. Store capture is qualified by it.
- `write_address`  in  8  CPU store address.
- `write_data`  in  32  CPU store data. Only bits [7:0] are transmitted.
- `write_enable`  in  1  CPU store strobe.
- `status_data`  out  32  `{28'b0, overflow, tx_idle, fifo_empty, fifo_full}`. Combinational from registers. The memory read mux selects it when `read_address == STATUS_ADDR`.
- `uart_tx`  out  1  serial line, idle high. Registered.

## Operation
- Store capture (push):
  - Occurs on a rising edge when `clk_enable && write_enable && write_address == TX_ADDR`.
  - If the FIFO is not full, `write_data[7:0]` is pushed.
  - If the FIFO is full, the byte is dropped and sticky `overflow` is set.
  - Fullness is evaluated before any same-edge pop: a push into a full FIFO is dropped even if a pop occurs on that edge.
- Overflow clear: a store to `STATUS_ADDR` with `write_data[3] == 1` (qualified the same way) clears `overflow`. A set and a clear on the same edge cannot happen, since the addresses differ.
- Transmitter FSM runs on every `clk` edge, independent of `clk_enable`:
  - IDLE: `uart_tx` = 1. If the FIFO is non-empty, pop the head into a shift register, load the baud counter with `CLKS_PER_BIT-1`, and go to START.
  - START: `uart_tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `uart_tx` = shift[0], LSB first. Each bit lasts `CLKS_PER_BIT` cycles. After bit 7, go to STOP.
  - STOP: `uart_tx` = 1 for `CLKS_PER_BIT` cycles.
    - At the end of STOP, if the FIFO is non-empty, pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- `tx_idle` = 1 only when the state is IDLE and the FIFO is empty.
- The baud counter is `$clog2(CLKS_PER_BIT)` bits wide, counts down, and reloads at zero.
- FIFO pointers are `$clog2(FIFO_DEPTH)+1` bits and wrap modulo 2·DEPTH.
  - full: indices equal and MSBs differ.
  - empty: pointers equal.

## Timing
- Reset values:
  - `uart_tx` = 1
  - state = IDLE
  - FIFO empty, so `status_data` = 32'h6 (`fifo_empty` = 1, `tx_idle` = 1)
  - `overflow` = 0
  - baud counter = 0
- Latency from an idle block:
  - store accepted on edge E0;
  - pop on edge E1;
  - `uart_tx` falls after edge E2 (registered output).
- Frame length is exactly 10·`CLKS_PER_BIT` cycles. Back-to-back frames are contiguous.
- A push and a pop on the same edge with a non-full FIFO both take effect, and the occupancy is unchanged.
- Reset asserted mid-frame aborts the frame. `uart_tx` is 1 after that edge, and FIFO contents are discarded.
- Stores with `clk_enable` = 0 are ignored, even when `write_enable` = 1.

## Configuration
- `MMIO_UART_TX_FIFO_EN` defined:
  - FIFO of `FIFO_DEPTH` entries as above.
- `MMIO_UART_TX_FIFO_EN` not defined:
  - The FIFO is replaced by a single holding register, so effective depth is 1 and `FIFO_DEPTH` is ignored.
  - `fifo_full` = holding register valid.
  - All other behaviour, including overflow and status, is identical.

## Structure
- Package `uart_pkg`:
  - FSM state enum `{IDLE, START, DATA, STOP}`.
  - Status bit indices: FULL=0, EMPTY=1, IDLE=2, OVF=3.
  - Default `TX_ADDR`/`STATUS_ADDR` constants.
- One sub-module, `sync_fifo`: parameterised width/depth; push/pop/full/empty/head. It is instantiated only under `MMIO_UART_TX_FIFO_EN`.
- The FSM, baud counter, and overflow flag live in `mmio_uart_tx`.

## Test plan
All scenarios use bench `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4, `clk_enable` tied high unless stated.
- Reset: hold `rst` 3 cycles → `uart_tx`=1, `status_data`=32'h6.
- Single byte: store 32'hDEAD_BE55 to 8'hF0 → `uart_tx` falls 2 edges later. Sampled mid-bit it reads 0,1,0,1,0,1,0,1,0,1 (start, 0x55 LSB-first, stop). 40-cycle frame, then `tx_idle`=1.
- Back-to-back: store 0x01, 0x02, 0x03 on consecutive cycles → three contiguous 40-cycle frames, no idle high gap between stop and next start.
- Overflow: 6 stores while the first frame is in flight → 1 in shift register, 4 queued, 1 dropped. `status_data[3]`=1, `fifo_full`=1 until the first pop. Store 32'h8 to 8'hF1 → `overflow`=0.
- Enable gating: store to 8'hF0 with `clk_enable`=0 → no frame, FIFO stays empty.
- Reset mid-frame: assert `rst` at cycle 10 of a frame with 2 bytes queued → `uart_tx`=1 next edge, `status_data`=32'h6, no further frames.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// The optional FIFO build is selected with MMIO_UART_TX_FIFO_EN (see mmio_uart_tx).
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Bit positions inside the status word
    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_IDLE  = 2;
    localparam int STAT_OVF   = 3;

    localparam logic [7:0] DEF_TX_ADDR     = 8'hF0;
    localparam logic [7:0] DEF_STATUS_ADDR = 8'hF1;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Small synchronous FIFO with pointer-MSB full/empty detection and a
// combinational head. Pushes into a full FIFO and pops from an empty one are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // Fullness is judged before any same-edge pop
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Store-snooping 8N1 UART transmitter with a polled status word.
// Define MMIO_UART_TX_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 104,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [7:0] TX_ADDR      = DEF_TX_ADDR,
    parameter logic [7:0] STATUS_ADDR  = DEF_STATUS_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_enable,
    input  logic [7:0]  write_address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    output logic [31:0] status_data,
    output logic        uart_tx
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_START = START;
    localparam logic [1:0] S_DATA  = DATA;
    localparam logic [1:0] S_STOP  = STOP;

    logic             push_req;
    logic             ovf_clr;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [7:0]       fifo_head;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             uart_tx_q, uart_tx_d;
    logic             overflow_q, overflow_d;
    logic             tx_idle;
    logic             unused_wdata;

    assign push_req     = clk_enable && write_enable && (write_address == TX_ADDR);
    assign ovf_clr      = clk_enable && write_enable && (write_address == STATUS_ADDR) && write_data[3];
    assign unused_wdata = ^write_data[31:8];

`ifdef MMIO_UART_TX_FIFO_EN
    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (write_data[7:0]),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );
`else
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       unused_depth;

    assign unused_depth = (FIFO_DEPTH < 2);

    // A pop only happens while valid, so it never races an accepted push
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (fifo_pop) begin
            hold_valid_d = 1'b0;
        end
        if (push_req && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_data_d  = write_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= 8'h00;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

    assign fifo_full  = hold_valid_q;
    assign fifo_empty = !hold_valid_q;
    assign fifo_head  = hold_data_q;
`endif

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        fifo_pop  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    baud_d   = BAUD_RELOAD;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (baud_q == '0) begin
                    baud_d    = BAUD_RELOAD;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            S_DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            S_STOP: begin
                // Chain straight into the next start bit when more data waits
                if (baud_q == '0) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        baud_d   = BAUD_RELOAD;
                        state_d  = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The line follows the current state one edge later
    always_comb begin
        case (state_q)
            S_START: uart_tx_d = 1'b0;
            S_DATA:  uart_tx_d = shift_q[0];
            default: uart_tx_d = 1'b1;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (push_req && fifo_full) begin
            overflow_d = 1'b1;
        end
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            shift_q    <= 8'h00;
            bit_idx_q  <= 3'd0;
            uart_tx_q  <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            uart_tx_q  <= uart_tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_idle = (state_q == S_IDLE) && fifo_empty;
    assign uart_tx = uart_tx_q;

    always_comb begin
        status_data             = 32'h0;
        status_data[STAT_FULL]  = fifo_full;
        status_data[STAT_EMPTY] = fifo_empty;
        status_data[STAT_IDLE]  = tx_idle;
        status_data[STAT_OVF]   = overflow_q;
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed scenarios plus random stores,
// compared every cycle against a frame-schedule model of the serial line and status word.
module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
`ifdef MMIO_UART_TX_FIFO_EN
    localparam int MDEPTH = DEPTH;
`else
    localparam int MDEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_enable = 1'b1;
    logic [7:0]  write_address = 8'h00;
    logic [31:0] write_data = 32'h0;
    logic        write_enable = 1'b0;
    logic [31:0] status_data;
    logic        uart_tx;

    int vectors = 0;
    int miscompares = 0;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .TX_ADDR      (8'hF0),
        .STATUS_ADDR  (8'hF1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_enable    (clk_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .status_data   (status_data),
        .uart_tx       (uart_tx)
    );

    always #5 clk = ~clk;

    // Model: bytes waiting in the queue, plus the current and previous frames
    // identified by the edge on which their byte left the queue.
    int         edge_n = 0;
    logic [7:0] q[$];
    bit         has_cur = 1'b0;
    bit         has_prv = 1'b0;
    int         cur_p = 0;
    int         prv_p = 0;
    logic [7:0] cur_b = 8'h00;
    logic [7:0] prv_b = 8'h00;
    bit         m_ovf = 1'b0;

    function automatic logic frame_bit(logic [7:0] b, int k);
        int bi;
        bi = k / CPB;
        if (bi == 0) return 1'b0;
        if (bi == 9) return 1'b1;
        return b[bi-1];
    endfunction

    function automatic logic exp_tx();
        if (has_cur && edge_n >= cur_p + 1 && edge_n <= cur_p + FRAME)
            return frame_bit(cur_b, edge_n - cur_p - 1);
        if (has_prv && edge_n >= prv_p + 1 && edge_n <= prv_p + FRAME)
            return frame_bit(prv_b, edge_n - prv_p - 1);
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status();
        logic idle;
        idle = (!has_cur || (edge_n - cur_p >= FRAME)) && (q.size() == 0);
        return {28'h0, m_ovf, idle, (q.size() == 0), (q.size() == MDEPTH)};
    endfunction

    task automatic model_edge();
        bit req;
        bit clr;
        bit do_pop;
        int occ;
        edge_n++;
        if (rst) begin
            q.delete();
            has_cur = 1'b0;
            has_prv = 1'b0;
            m_ovf   = 1'b0;
            return;
        end
        req    = clk_enable && write_enable && (write_address == 8'hF0);
        clr    = clk_enable && write_enable && (write_address == 8'hF1) && write_data[3];
        occ    = q.size();
        do_pop = (occ > 0) && (!has_cur || (edge_n - cur_p >= FRAME));
        if (req && occ >= MDEPTH) m_ovf = 1'b1;
        if (do_pop) begin
            prv_p   = cur_p;
            prv_b   = cur_b;
            has_prv = has_cur;
            cur_p   = edge_n;
            cur_b   = q.pop_front();
            has_cur = 1'b1;
        end
        if (req && occ < MDEPTH) q.push_back(write_data[7:0]);
        if (clr) m_ovf = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h at edge %0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic cyc(input bit r, input bit ce, input bit we,
                       input logic [7:0] a, input logic [31:0] d);
        rst           = r;
        clk_enable    = ce;
        write_enable  = we;
        write_address = a;
        write_data    = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("uart_tx", {31'h0, uart_tx}, {31'h0, exp_tx()});
        check("status", status_data, exp_status());
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic store(input logic [7:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b1, a, d);
    endtask

    initial begin
        int k;
        int r;

        // Reset held for three cycles
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 8'h00, 32'h0);
        check("reset_status", status_data, 32'h6);
        check("reset_tx", {31'h0, uart_tx}, 32'h1);

        // Single byte 0x55, sampled mid-bit
        store(8'hF0, 32'hDEAD_BE55);
        for (int n = 1; n <= 44; n++) begin
            idle(1);
            k = n - 2;
            if (k >= 0 && k < FRAME && (k % CPB) == CPB / 2)
                check("midbit", {31'h0, uart_tx}, 32'((k / CPB) % 2));
        end
        check("idle_after_frame", status_data, 32'h6);

        // Back-to-back stores
        store(8'hF0, 32'h01);
        store(8'hF0, 32'h02);
        store(8'hF0, 32'h03);
        idle(130);

        // Overflow while the first frame is in flight, then clear it
        for (int n = 0; n < 6; n++) store(8'hF0, $urandom());
        check("overflow_set", {31'h0, status_data[3]}, 32'h1);
        idle(100);
        store(8'hF1, 32'h8);
        check("overflow_clr", {31'h0, status_data[3]}, 32'h0);
        idle(200);

        // Stores without clk_enable are ignored
        cyc(1'b0, 1'b0, 1'b1, 8'hF0, $urandom());
        idle(50);
        check("gated_status", status_data, 32'h6);

        // Reset ten cycles into a frame with bytes queued
        for (int n = 0; n < 3; n++) store(8'hF0, $urandom());
        idle(9);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 32'h0);
        check("midreset_status", status_data, 32'h6);
        check("midreset_tx", {31'h0, uart_tx}, 32'h1);
        idle(60);

        // Random store traffic
        for (int n = 0; n < 700; n++) begin
            r = int'($urandom_range(0, 199));
            if (r < 14)       store(8'hF0, $urandom());
            else if (r < 18)  store(8'hF1, $urandom());
            else if (r < 22)  cyc(1'b0, 1'b0, 1'b1, 8'hF0, $urandom());
            else if (r < 25)  store(8'(8'h80 + $urandom_range(0, 15)), $urandom());
            else if (r == 199) cyc(1'b1, 1'b1, 1'b0, 8'h00, 32'h0);
            else              idle(1);
        end
        idle(FRAME * (MDEPTH + 2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
